// File: rtl/alu_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ex_stage_pkg
// Description : Shared definitions for the ALU control decoder and the
//               execute stage: ALU select codes, default widths and the
//               execute-stage skid-buffer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ex_stage_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int TAGW_DEFAULT = 5;

  // ALU select codes shared with the ALU control decoder.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // main and skid empty
    ST_FULL  = 2'd1,  // main held
    ST_SKID  = 2'd2   // main and skid held
  } ex_state_t;

endpackage : alu_ex_stage_pkg
`default_nettype wire

// File: rtl/alu_ex_stage_alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Purely combinational ALU. Add/sub wrap modulo 2^XLEN,
//               bitwise and/or. Unknown select codes yield result 0 with
//               the illegal flag set.
// Ports       : alu_sel - 4-bit select code
//               op_a    - operand A
//               op_b    - operand B
//               result  - ALU result
//               zero    - result == 0
//               illegal - alu_sel not a legal code
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
  import alu_ex_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  logic [XLEN-1:0] w_result;
  logic            w_illegal;

  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    case (alu_sel)
      ALU_ADD: w_result = op_a + op_b;
      ALU_SUB: w_result = op_a - op_b;
      ALU_AND: w_result = op_a & op_b;
      ALU_OR:  w_result = op_a | op_b;
      default: w_illegal = 1'b1;
    endcase
  end

  assign result  = w_result;
  // An illegal code forces result 0, so zero is naturally 1 for it.
  assign zero    = (w_result == '0);
  assign illegal = w_illegal;

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_ex_stage
// Description : Execute stage. Computes the ALU result for each accepted
//               operation and holds it in a two-entry skid buffer (main +
//               skid) between valid/ready handshakes. in_ready is
//               registered so the upstream never sees a combinational path
//               from out_ready. One operation per cycle throughput.
// Ports       : clk, rst_n (async active-low), flush (sync, drops all)
//               in_valid/in_ready, alu_sel, op_a, op_b, rd_in - upstream
//               out_valid/out_ready, result, zero, illegal, rd_out - down
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ex_stage
  import alu_ex_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int TAGW = TAGW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [TAGW-1:0] rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic [TAGW-1:0] rd_out
);

  logic [XLEN-1:0] w_alu_result;
  logic            w_alu_zero;
  logic            w_alu_illegal;

  alu_core #(
    .XLEN (XLEN)
  ) u_alu_core (
    .alu_sel (alu_sel),
    .op_a    (op_a),
    .op_b    (op_b),
    .result  (w_alu_result),
    .zero    (w_alu_zero),
    .illegal (w_alu_illegal)
  );

  ex_state_t       r_state;
  ex_state_t       w_state_next;
  logic            r_in_ready;

  logic [XLEN-1:0] r_main_result;
  logic            r_main_zero;
  logic            r_main_illegal;
  logic [TAGW-1:0] r_main_rd;

  logic [XLEN-1:0] r_skid_result;
  logic            r_skid_zero;
  logic            r_skid_illegal;
  logic [TAGW-1:0] r_skid_rd;

  logic            w_out_valid;
  logic            w_accept;
  logic            w_pop;
  logic            w_load_main_new;
  logic            w_load_main_skid;
  logic            w_load_skid;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_accept    = in_valid & r_in_ready;
  assign w_pop       = w_out_valid & out_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_load_main_new  = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      // Flush wins over any same-cycle accept or pop; nothing is loaded.
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_next    = ST_FULL;
            w_load_main_new = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_accept && !w_pop) begin
            w_state_next = ST_SKID;
            w_load_skid  = 1'b1;
          end else if (w_accept && w_pop) begin
            w_load_main_new = 1'b1;
          end else if (w_pop) begin
            w_state_next = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (w_pop) begin
            w_state_next     = ST_FULL;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  // in_ready is a flop that anticipates the next state, keeping it free of
  // any combinational dependence on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= (w_state_next != ST_SKID);
    end
  end

  // ---------------------------------------------------------- data path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_result  <= '0;
      r_main_zero    <= 1'b0;
      r_main_illegal <= 1'b0;
      r_main_rd      <= '0;
    end else if (w_load_main_new) begin
      r_main_result  <= w_alu_result;
      r_main_zero    <= w_alu_zero;
      r_main_illegal <= w_alu_illegal;
      r_main_rd      <= rd_in;
    end else if (w_load_main_skid) begin
      r_main_result  <= r_skid_result;
      r_main_zero    <= r_skid_zero;
      r_main_illegal <= r_skid_illegal;
      r_main_rd      <= r_skid_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_result  <= '0;
      r_skid_zero    <= 1'b0;
      r_skid_illegal <= 1'b0;
      r_skid_rd      <= '0;
    end else if (w_load_skid) begin
      r_skid_result  <= w_alu_result;
      r_skid_zero    <= w_alu_zero;
      r_skid_illegal <= w_alu_illegal;
      r_skid_rd      <= rd_in;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign result    = r_main_result;
  assign zero      = r_main_zero;
  assign illegal   = r_main_illegal;
  assign rd_out    = r_main_rd;

endmodule : alu_ex_stage
`default_nettype wire
